// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST-9 fetch sequencer.
package fd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StReady,
        StDone
    } state_e;

    // Centres keep this many pixels clear of every image edge.
    localparam int unsigned BORDER    = 3;
    // Slot 0 is the centre, slots 1..16 are the circle pixels.
    localparam int unsigned NUM_SLOTS = 17;
    localparam int unsigned IDX_W     = 5;

    // Bresenham radius-3 circle, clockwise from twelve o'clock; entry k is slot k+1.
    localparam logic signed [2:0] CIRCLE_DX [16] = '{
        3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };
    localparam logic signed [2:0] CIRCLE_DY [16] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
        3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3
    };

endpackage

// File: rtl/fd_fetch_ctrl_if.sv
// Control/SRAM/register-file signal bundle of the fetch sequencer.
interface fd_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CW     = 6
);

    logic              start;
    logic              ack;
    logic              sramRe;
    logic [ADDR_W-1:0] sramAddr;
    logic              regWe;
    logic [4:0]        regAddr;
    logic              readen;
    logic [CW-1:0]     centerX;
    logic [CW-1:0]     centerY;
    logic              busy;
    logic              frameDone;

    // Sequencer side.
    modport master (
        input  start, ack,
        output sramRe, sramAddr, regWe, regAddr, readen, centerX, centerY, busy, frameDone
    );

    // Controller/detector side.
    modport slave (
        output start, ack,
        input  sramRe, sramAddr, regWe, regAddr, readen, centerX, centerY, busy, frameDone
    );

endinterface

// File: rtl/fd_circle_offset.sv
// Slot index to pixel offset lookup; slot 0 (and any unused code) is the centre itself.
module fd_circle_offset
    import fd_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    output logic signed [2:0] dx_o,
    output logic signed [2:0] dy_o
);

    logic [3:0] lut_idx;

    assign lut_idx = 4'(idx_i - IDX_W'(1));

    // Table lookup, circle slots only.
    always_comb begin
        dx_o = '0;
        dy_o = '0;
        if ((idx_i != '0) && (idx_i < IDX_W'(NUM_SLOTS))) begin
            dx_o = CIRCLE_DX[lut_idx];
            dy_o = CIRCLE_DY[lut_idx];
        end
    end

endmodule

// File: rtl/fd_fetch_ctrl.sv
// Raster-order fetch sequencer feeding the FAST-9 pixel register file.
module fd_fetch_ctrl
    import fd_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CW     = 6
) (
    input logic            clock,
    input logic            reset,
    fd_fetch_ctrl_if.master bus
);

    localparam logic [CW-1:0]     CoordFirst = CW'(BORDER);
    localparam logic [CW-1:0]     XLast      = CW'(IMG_W - BORDER - 1);
    localparam logic [CW-1:0]     YLast      = CW'(IMG_H - BORDER - 1);
    localparam logic [IDX_W-1:0]  IdxLast    = IDX_W'(NUM_SLOTS - 1);
    localparam logic [ADDR_W-1:0] RowPitch   = ADDR_W'(IMG_W);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic              we_q;
    logic [IDX_W-1:0]  waddr_q;

    logic signed [2:0] dx, dy;
    logic signed [CW:0] px, py;
    logic [ADDR_W-1:0] col, row;
    logic              last_centre;

    fd_circle_offset u_offset (
        .idx_i (idx_q),
        .dx_o  (dx),
        .dy_o  (dy)
    );

    assign last_centre = (x_q == XLast) && (y_q == YLast);

    // Border keeps px/py non-negative, so the signed sums zero-extend safely.
    assign px  = $signed({1'b0, x_q}) + $signed({{(CW-2){dx[2]}}, dx});
    assign py  = $signed({1'b0, y_q}) + $signed({{(CW-2){dy[2]}}, dy});
    assign col = {{(ADDR_W-CW-1){1'b0}}, px};
    assign row = {{(ADDR_W-CW-1){1'b0}}, py};

    // Next-state logic: slot counter and centre raster walk.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    x_d     = CoordFirst;
                    y_d     = CoordFirst;
                end
            end
            StFetch: begin
                if (idx_q == IdxLast) begin
                    state_d = StDrain;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: state_d = StReady;
            StReady: begin
                if (bus.ack) begin
                    if (last_centre) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                        idx_d   = '0;
                        if (x_q == XLast) begin
                            x_d = CoordFirst;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers plus the one-cycle write delay matching SRAM read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            we_q    <= (state_q == StFetch);
            waddr_q <= idx_q;
        end
    end

    assign bus.sramRe    = (state_q == StFetch);
    assign bus.sramAddr  = row * RowPitch + col;
    assign bus.regWe     = we_q;
    assign bus.regAddr   = waddr_q;
    assign bus.readen    = (state_q == StReady);
    assign bus.centerX   = x_q;
    assign bus.centerY   = y_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frameDone = (state_q == StDone);

endmodule

// File: tb/tb_fd_fetch_ctrl.sv
// Scoreboard bench for fd_fetch_ctrl on a 16x16 image.
module tb_fd_fetch_ctrl;

    localparam int W   = 16;
    localparam int H   = 16;
    localparam int AW  = 8;
    localparam int CWB = 4;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fd_fetch_ctrl_if #(.ADDR_W(AW), .CW(CWB)) bus ();

    fd_fetch_ctrl #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW),
        .CW     (CWB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Expected circle offsets by slot (slot 0 = centre).
    int dxs [17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int dys [17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } rec_t;

    rec_t q_fetch[$];
    rec_t q_wr[$];
    rec_t q_rdy[$];
    rec_t q_fall[$];
    rec_t q_done[$];
    rec_t q_quiet[$];

    int n_total = 0;
    int n_bad = 0;
    int n_timeout = 0;
    bit end_req = 1'b0;

    function automatic int addr_of(int cx, int cy, int i);
        return (cy + dys[i]) * W + (cx + dxs[i]);
    endfunction

    // Expectations for one set whose idx0 read appears at cycle e0; nf < 17 = cut short.
    function automatic void push_set(int e0, int cx, int cy, int nf);
        int nw;
        nw = (nf == 17) ? 17 : nf - 1;
        for (int i = 0; i < nf; i++) q_fetch.push_back('{e0 + i, addr_of(cx, cy, i), cx, cy});
        for (int i = 0; i < nw; i++) q_wr.push_back('{e0 + 1 + i, i, 0, 0});
        if (nf == 17) q_rdy.push_back('{e0 + 18, cx, cy, 0});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows an event.
    initial begin : monitor
        rec_t r;
        bit   rdy_prev;
        int   cur_cx, cur_cy;
        rdy_prev = 1'b0;
        cur_cx = 0;
        cur_cy = 0;
        forever begin
            @(negedge clock);
            if (bus.sramRe === 1'b1) begin
                if (q_fetch.size() == 0) chk("fetch_unexpected", int'(bus.sramRe), 0);
                else begin
                    r = q_fetch.pop_front();
                    chk("fetch_cyc", cyc, r.cyc);
                    chk("fetch_addr", int'(bus.sramAddr), r.a);
                    chk("fetch_cx", int'(bus.centerX), r.b);
                    chk("fetch_cy", int'(bus.centerY), r.c);
                end
            end else if (q_fetch.size() > 0 && q_fetch[0].cyc <= cyc) begin
                chk("fetch_missing", int'(bus.sramRe), 1);
                void'(q_fetch.pop_front());
            end
            if (bus.regWe === 1'b1) begin
                if (q_wr.size() == 0) chk("write_unexpected", int'(bus.regWe), 0);
                else begin
                    r = q_wr.pop_front();
                    chk("write_cyc", cyc, r.cyc);
                    chk("write_slot", int'(bus.regAddr), r.a);
                end
            end else if (q_wr.size() > 0 && q_wr[0].cyc <= cyc) begin
                chk("write_missing", int'(bus.regWe), 1);
                void'(q_wr.pop_front());
            end
            if (bus.readen === 1'b1 && !rdy_prev) begin
                if (q_rdy.size() == 0) chk("readen_unexpected", int'(bus.readen), 0);
                else begin
                    r = q_rdy.pop_front();
                    chk("readen_cyc", cyc, r.cyc);
                    cur_cx = r.a;
                    cur_cy = r.b;
                end
            end else if (q_rdy.size() > 0 && q_rdy[0].cyc <= cyc) begin
                chk("readen_missing", int'(bus.readen), 1);
                void'(q_rdy.pop_front());
            end
            if (bus.readen === 1'b1) begin
                chk("hold_cx", int'(bus.centerX), cur_cx);
                chk("hold_cy", int'(bus.centerY), cur_cy);
            end
            if (bus.readen !== 1'b1 && rdy_prev) begin
                if (q_fall.size() == 0) chk("readen_drop_unexpected", int'(bus.readen), 1);
                else begin
                    r = q_fall.pop_front();
                    chk("readen_fall_cyc", cyc, r.cyc);
                end
            end else if (q_fall.size() > 0 && q_fall[0].cyc <= cyc) begin
                chk("readen_fall_missing", int'(bus.readen), 0);
                void'(q_fall.pop_front());
            end
            if (bus.frameDone === 1'b1) begin
                if (q_done.size() == 0) chk("done_unexpected", int'(bus.frameDone), 0);
                else begin
                    r = q_done.pop_front();
                    chk("done_cyc", cyc, r.cyc);
                end
            end else if (q_done.size() > 0 && q_done[0].cyc <= cyc) begin
                chk("done_missing", int'(bus.frameDone), 1);
                void'(q_done.pop_front());
            end
            while (q_quiet.size() > 0 && q_quiet[0].cyc <= cyc) begin
                r = q_quiet.pop_front();
                chk("quiet_busy", int'(bus.busy), 0);
                chk("quiet_frameDone", int'(bus.frameDone), 0);
                if (r.c == 1) begin
                    chk("quiet_sramRe", int'(bus.sramRe), 0);
                    chk("quiet_sramAddr", int'(bus.sramAddr), 0);
                    chk("quiet_regWe", int'(bus.regWe), 0);
                    chk("quiet_regAddr", int'(bus.regAddr), 0);
                    chk("quiet_readen", int'(bus.readen), 0);
                    chk("quiet_centerX", int'(bus.centerX), 0);
                    chk("quiet_centerY", int'(bus.centerY), 0);
                end
            end
            rdy_prev = (bus.readen === 1'b1);
            if (end_req) begin
                chk("left_fetch", q_fetch.size(), 0);
                chk("left_write", q_wr.size(), 0);
                chk("left_readen", q_rdy.size(), 0);
                chk("left_fall", q_fall.size(), 0);
                chk("left_done", q_done.size(), 0);
                chk("left_quiet", q_quiet.size(), 0);
                chk("wait_timeouts", n_timeout, 0);
                $display("test done: total=%0d bad=%0d", n_total, n_bad);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    task automatic start_frame();
        bus.start = 1'b1;
        push_set(cyc + 1, 3, 3, 17);
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_readen();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (bus.readen === 1'b1) ok = 1'b1;
        end
        if (!ok) n_timeout++;
    endtask

    // Call at a negedge with readen high; ack is sampled at the next edge.
    task automatic ack_set(input int ncx, input int ncy, input bit last, input int nf);
        int n;
        bus.ack = 1'b1;
        n = cyc + 1;
        q_fall.push_back('{n, 0, 0, 0});
        if (last) begin
            q_done.push_back('{n, 0, 0, 0});
            q_quiet.push_back('{n + 1, 0, 0, 0});
        end else begin
            push_set(n, ncx, ncy, nf);
        end
        @(negedge clock);
        bus.ack = 1'b0;
    endtask

    initial begin : stimulus
        int e0;
        int done_cyc;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        for (int i = 1; i <= 3; i++) q_quiet.push_back('{i, 0, 0, 1});
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Frame 1: ack tied high, 100 back-to-back sets, wrap and frame end.
        bus.start = 1'b1;
        bus.ack = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 100; k++) begin
            push_set(e0 + 19 * k, 3 + k % 10, 3 + k / 10, 17);
            q_fall.push_back('{e0 + 19 * k + 19, 0, 0, 0});
        end
        done_cyc = e0 + 19 * 99 + 19;
        q_done.push_back('{done_cyc, 0, 0, 0});
        q_quiet.push_back('{done_cyc + 1, 0, 0, 0});
        @(negedge clock);
        bus.start = 1'b0;
        while (cyc < done_cyc + 3) @(negedge clock);
        bus.ack = 1'b0;
        @(negedge clock);

        // Frame 2: stall, ignored inputs, then reset at idx 7 of the fifth set.
        start_frame();
        wait_readen();
        repeat (50) @(negedge clock);
        ack_set(4, 3, 1'b0, 17);
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.ack = 1'b1;
        @(negedge clock);
        bus.ack = 1'b0;
        wait_readen();
        ack_set(5, 3, 1'b0, 17);
        wait_readen();
        ack_set(6, 3, 1'b0, 17);
        wait_readen();
        ack_set(7, 3, 1'b0, 8);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        q_quiet.push_back('{cyc + 1, 0, 0, 1});
        q_quiet.push_back('{cyc + 2, 0, 0, 1});
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Frame 3: restart resumes at (3,3).
        start_frame();
        wait_readen();
        ack_set(4, 3, 1'b0, 17);
        wait_readen();
        repeat (3) @(negedge clock);
        end_req = 1'b1;
    end

endmodule

// File: doc/fd_fetch_ctrl.md
# fd_fetch_ctrl

Fetch sequencer directly upstream of the FAST-9 pixel register file. It scans every valid corner-candidate centre of a frame in raster order, reads the centre pixel and its 16 Bresenham radius-3 circle pixels from the image SRAM, and steers each returned byte into register-file slot 0..16. It then raises `readen` and holds the set until the downstream detector acknowledges it.

## Interface
Parameters:
- `IMG_W`, default 64: image width in pixels.
- `IMG_H`, default 64: image height in pixels.
- `ADDR_W`, default 12: SRAM byte-address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- `CW`, default 6: coordinate width, equal to clog2(max(IMG_W, IMG_H)).

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame scan; sampled only in IDLE.
- `ack`  in  1  downstream has consumed the current pixel set; sampled only while `readen`=1.
- `sramRe`  out  1  SRAM read strobe.
- `sramAddr`  out  ADDR_W  SRAM read address.
- `regWe`  out  1  register-file write enable for the byte currently on the SRAM data bus.
- `regAddr`  out  5  target slot: 0 = centre, 1..16 = circle pixel.
- `readen`  out  1  all 17 slots hold the current centre's data.
- `centerX`, `centerY`  out  CW each  coordinates of the current centre.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frameDone`  out  1  single-cycle pulse after the last set is acknowledged.

## Operation
- **Centres:** x runs 3..IMG_W-4 and y runs 3..IMG_H-4, with x varying fastest.
- **Circle offsets (dx, dy), idx 1..16:** (0,-3) (1,-3) (2,-2) (3,-1) (3,0) (3,1) (2,2) (1,3) (0,3) (-1,3) (-2,2) (-3,1) (-3,0) (-3,-1) (-2,-2) (-1,-3). idx 0 is (0,0).
- **Address:** `sramAddr` = (y+dy)·IMG_W + (x+dx).
  - Compute in signed CW+1 bits, then zero-extend to ADDR_W.
  - The 3-pixel border guarantees no underflow or overflow, so no clamping is needed.
- **States:**
  - IDLE: on `start` → FETCH with idx=0 and centre=(3,3).
  - FETCH: `sramRe`=1 and idx increments each cycle. At idx=16 → DRAIN.
  - DRAIN: last write only (`sramRe`=0, `regWe`=1) → READY.
  - READY: `readen`=1 and held indefinitely. On `ack`:
    - if the centre is not last, advance it (wrap x to 3 and increment y at x=IMG_W-4) and go to FETCH with idx=0;
    - if the centre is last, go to DONE.
  - DONE: `frameDone`=1 for one cycle → IDLE.
- **Write path:** `regWe` and `regAddr` are the one-cycle-delayed copies of `sramRe` and idx, matching the SRAM's one-cycle read latency.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `ack` outside READY is ignored.
  - `ack` held high over several cycles counts once per READY entry.
- **Reset:** `reset` at any point, including mid-FETCH or in READY, forces IDLE next cycle. No partial set is flagged ready.

## Timing
- **Reset values:** every output is 0.
  - Internal idx, x, y and the pipeline delay register are also 0.
- **Frame start:** with `start` sampled at edge E0:
  - `sramRe`=1 after edges E0..E16 (17 cycles);
  - `regWe`=1 after E1..E17, with `regAddr` = 0..16 in order;
  - `readen`=1 after E18.
- **Per-set cost:** 18 cycles from FETCH entry to `readen`, plus the cycles spent waiting for `ack`.
- **Next set:** with `ack` sampled at edge N, `readen` drops and `sramRe` rises after N. There is no idle bubble.
- **Coordinate stability:** `centerX` and `centerY` change only on the READY→FETCH transition, so they are stable for the entire fetch and READY window of a set.
- **Frame end:** with the last set's `ack` sampled at N, `frameDone`=1 after N; `busy` and `frameDone` are both 0 after N+1.

## Structure
- **Package `fd_pkg`:**
  - state enum (IDLE, FETCH, DRAIN, READY, DONE);
  - `BORDER`=3;
  - `NUM_SLOTS`=17;
  - the 16-entry signed 3-bit dx and dy constant arrays.
- **Sub-module `fd_circle_offset`:** combinational lookup from idx[4:0] to signed dx and dy.
- **Top level:** FSM, coordinate counters, address adder, one-stage delay for `regWe`/`regAddr`.

## Test plan
All scenarios use IMG_W=IMG_H=16.
- **First set addresses:** `start` → for centre (3,3), `sramAddr` for idx 0/1/5/9/13 = 51/3/54/99/48. `readen` rises 18 cycles after `start` is sampled, and `regAddr` runs 0..16 exactly one cycle behind `sramRe`.
- **Back-to-back acknowledge:** `ack` tied high → 100 sets with centres (3,3), (4,3) … (12,3), (3,4) … (12,12). The second set's idx0 address is 52, and the cycle after each `readen` is `sramRe`=1. One `frameDone` pulse; `busy`=0 afterwards.
- **Stalled acknowledge:** `ack` withheld for 50 cycles → `readen`, `centerX`, `centerY` stable and `sramRe`=0 for the whole stall; the next fetch starts the cycle after `ack`.
- **Reset mid-fetch:** `reset` asserted at idx=7 of set 5 → all outputs 0 next cycle and state IDLE. A new `start` resumes at centre (3,3).
- **Ignored inputs:** `start` while busy and `ack` while `readen`=0 → no change to the sequence or counters.
- **Wrap and frame end:** `ack` at centre (12,12) → `frameDone` for exactly one cycle, no `sramRe` issued, `busy`=0.
